binary_to_bcd_converter: RTL and testbench
==========================================

BINARY_TO_BCD_CONVERTER -- requirements
Module: binary_to_bcd_converter

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 14, giving the binary input width (0..16383).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD output digits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to convert bin, sampled only in IDLE.
REQ-006 SHALL have port bin, input, BIN_WIDTH bits: unsigned value to convert.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress (SHIFT or DONE).
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking new valid outputs.
REQ-009 SHALL have port ovf, output, 1 bit: captured value exceeded 9999.
REQ-010 SHALL have ports BCD0, BCD1, BCD2, BCD3, outputs, 4 bits each: ones, tens, hundreds and thousands digits, driving the four-digit display inputs directly.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-012 SHALL, in IDLE with start=1, capture bin into a shift register, clear the 16-bit BCD scratch, load the bit counter with BIN_WIDTH, and go to SHIFT.
REQ-013 SHALL, each SHIFT cycle, add 3 to every scratch digit >=5, then shift {scratch, shift register} left by one bit, and decrement the counter.
REQ-014 SHALL go from SHIFT to DONE on the cycle the counter reaches 0, after exactly BIN_WIDTH shift cycles (14 by default).
REQ-015 SHALL, in DONE, load BCD0..BCD3 and ovf from the scratch, assert done for exactly one cycle, and return to IDLE on the next edge.
REQ-016 SHALL have a fixed latency: if start is sampled at edge k, done is high in the cycle after edge k+BIN_WIDTH+1 (edge k+15 by default), independent of the value.
REQ-017 SHALL ignore start whenever busy=1; the captured operand is unaffected by later changes to bin.
REQ-018 SHALL, when start is high continuously, accept a new conversion on the first IDLE cycle after DONE.
REQ-019 SHALL, when the captured value >9999, run the full latency and then present all four digits as 4'hA with ovf=1; the downstream decoder shows this as 'X'.
REQ-020 SHALL hold BCD0..BCD3 and ovf stable from one done to the next.
REQ-021 SHALL generate no done pulse for an aborted conversion.

Reset
REQ-022 SHALL, while reset=1 at a rising edge, force state IDLE, busy=0, done=0, ovf=0 and BCD0..BCD3=0.
REQ-023 SHALL, on reset during SHIFT or DONE, abort immediately with no done pulse; outputs return to 0.
REQ-024 SHALL give reset priority over start in the same cycle.

Structure
REQ-025 SHALL take BIN_WIDTH, NUM_DIGITS, the overflow digit code 4'hA, the limit 9999 and the state encodings from a shared package used by the display blocks.
REQ-026 SHALL instantiate one combinational sub-module, bcd_add3 (4-bit in, 4-bit out, adds 3 when >=5), once per digit.
REQ-027 SHALL keep all registers in one clocked process; next-state and digit correction are combinational.

Verification
REQ-028 SHALL check: bin=0, start pulse -> done at edge+15; BCD3..0 = 0,0,0,0; ovf=0.
REQ-029 SHALL check: bin=1234 -> BCD3..0 = 1,2,3,4; busy high for 15 cycles; done high for exactly 1 cycle.
REQ-030 SHALL check: bin=9999 -> 9,9,9,9 with ovf=0; then bin=10000 -> A,A,A,A with ovf=1.
REQ-031 SHALL check: start with bin=42, then start with bin=7 five cycles later -> second start ignored; result 0,0,4,2.
REQ-032 SHALL check: reset asserted 6 cycles into a conversion of 5678 -> no done; outputs 0; a new start with 5678 gives 5,6,7,8.
REQ-033 SHALL check: start held high constantly with bin=305 -> done every 16 cycles; outputs 0,3,0,5 each time.

Source files
------------

// File: rtl/binary_to_bcd_converter_pkg.sv
// Constants shared by the binary-to-BCD converter and the display blocks it drives.
// Digit code 4'hA marks an out-of-range value; the decoder renders it as 'X'.
package binary_to_bcd_converter_pkg;

  localparam int          BIN_WIDTH_DEF  = 14;
  localparam int          NUM_DIGITS_DEF = 4;
  localparam int unsigned BCD_LIMIT      = 9999;
  localparam logic [3:0]  BCD_OVF_DIGIT  = 4'hA;

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_SHIFT = 2'd1;
  localparam logic [1:0]  ST_DONE  = 2'd2;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more. Combinational.
// No handshake; zero latency.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble converter: one bit per cycle, done BIN_WIDTH+1 edges after start.
// start is ignored while busy; results hold until the next done pulse.
module binary_to_bcd_converter
  import binary_to_bcd_converter_pkg::*;
#(
  parameter int BIN_WIDTH  = BIN_WIDTH_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output bcd_digit_t           BCD0,
  output bcd_digit_t           BCD1,
  output bcd_digit_t           BCD2,
  output bcd_digit_t           BCD3
);

  localparam int SW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  logic [1:0]           state_q, state_d;
  logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
  logic [SW-1:0]        scratch_q, scratch_d, scratch_adj;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [3:0][3:0]      digits_q, digits_d;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (scratch_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d    = bin;
          scratch_d  = '0;
          cnt_d      = CW'(BIN_WIDTH);
          // Range is decided on the operand itself: 4 digits cannot hold 10000..16383.
          ovf_pend_d = (32'(bin) > BCD_LIMIT);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        ovf_d  = ovf_pend_q;
        for (int i = 0; i < 4; i++) begin
          digits_d[i] = ovf_pend_q ? BCD_OVF_DIGIT : scratch_q[4*i +: 4];
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign BCD0 = digits_q[0];
  assign BCD1 = digits_q[1];
  assign BCD2 = digits_q[2];
  assign BCD3 = digits_q[3];

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Bench for binary_to_bcd_converter: directed scenarios plus random operands
// compared against a decimal-arithmetic reference with a fixed 15-edge latency.
module tb_binary_to_bcd_converter;

  localparam int LAT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic        busy, done, ovf;
  logic [3:0]  BCD0, BCD1, BCD2, BCD3;

  int total = 0;
  int bad   = 0;

  binary_to_bcd_converter #(.BIN_WIDTH(14), .NUM_DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .BCD0  (BCD0),
    .BCD1  (BCD1),
    .BCD2  (BCD2),
    .BCD3  (BCD3)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_bcd(input int v);
    if (v > 9999) return 16'hAAAA;
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] bcd_out();
    return {BCD3, BCD2, BCD1, BCD0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one conversion of v, scrambles bin while busy, and watches 25 edges.
  task automatic convert(input int v, output int lat, output int bcyc, output int dcyc);
    lat = -1; bcyc = 0; dcyc = 0;
    bin = 14'(v); start = 1'b1;
    step();
    start = 1'b0;
    bin = 14'($urandom);
    if (busy) bcyc++;
    for (int i = 1; i <= 25; i++) begin
      step();
      bin = 14'($urandom);
      if (busy) bcyc++;
      if (done) begin
        dcyc++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bin = '0;
    step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (bcd_out() !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", bcd_out()); end
    start = 1'b1; bin = 14'd1234;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_prio_busy got=%b exp=0", busy); end
    reset = 1'b0; start = 1'b0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_prio_idle got=%b exp=0", busy); end
  endtask

  task automatic test_zero();
    int lat, bc, dc;
    convert(0, lat, bc, dc);
    total++; if (lat !== LAT) begin bad++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (bcd_out() !== 16'h0000) begin bad++; $display("FAIL zero_bcd got=%h exp=0000", bcd_out()); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL zero_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_1234();
    int lat, bc, dc;
    convert(1234, lat, bc, dc);
    total++; if (bcd_out() !== 16'h1234) begin bad++; $display("FAIL v1234_bcd got=%h exp=1234", bcd_out()); end
    total++; if (bc !== LAT) begin bad++; $display("FAIL v1234_busy_cycles got=%0d exp=%0d", bc, LAT); end
    total++; if (dc !== 1) begin bad++; $display("FAIL v1234_done_cycles got=%0d exp=1", dc); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL v1234_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_limits();
    int lat, bc, dc;
    convert(9999, lat, bc, dc);
    total++; if (bcd_out() !== 16'h9999) begin bad++; $display("FAIL v9999_bcd got=%h exp=9999", bcd_out()); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL v9999_ovf got=%b exp=0", ovf); end
    convert(10000, lat, bc, dc);
    total++; if (bcd_out() !== 16'hAAAA) begin bad++; $display("FAIL v10000_bcd got=%h exp=aaaa", bcd_out()); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL v10000_ovf got=%b exp=1", ovf); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL v10000_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    int dc = 0;
    bin = 14'd42; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      start = (i == 5);
      if (i == 5) bin = 14'd7;
      step();
      if (done) begin
        dc++;
        if (lat < 0) lat = i;
      end
    end
    start = 1'b0;
    total++; if (lat !== LAT) begin bad++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (dc !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dc); end
    total++; if (bcd_out() !== 16'h0042) begin bad++; $display("FAIL ignore_bcd got=%h exp=0042", bcd_out()); end
  endtask

  task automatic test_abort();
    int lat, bc, dc;
    int seen = 0;
    bin = 14'd5678; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (bcd_out() !== 16'h0000) begin bad++; $display("FAIL abort_bcd got=%h exp=0000", bcd_out()); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL abort_ovf got=%b exp=0", ovf); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    convert(5678, lat, bc, dc);
    total++; if (bcd_out() !== 16'h5678) begin bad++; $display("FAIL abort_retry_bcd got=%h exp=5678", bcd_out()); end
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int n = 0;
    bin = 14'd305; start = 1'b1;
    step();
    for (int i = 1; i <= 80; i++) begin
      step();
      if (done) begin
        n++;
        total++;
        if ((last < 0 && i !== LAT) || (last >= 0 && i - last !== 16)) begin
          bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", i, (last < 0) ? LAT : last + 16);
        end
        total++; if (bcd_out() !== 16'h0305) begin bad++; $display("FAIL b2b_bcd got=%h exp=0305", bcd_out()); end
        last = i;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    total++; if (n !== 5) begin bad++; $display("FAIL b2b_done_count got=%0d exp=5", n); end
  endtask

  task automatic test_random();
    int lat, bc, dc, v;
    for (int n = 0; n < 25; n++) begin
      v = (n == 0) ? 16383 : (n == 1) ? 10 : int'($urandom_range(0, 16383));
      convert(v, lat, bc, dc);
      total++; if (bcd_out() !== model_bcd(v)) begin bad++; $display("FAIL rand_bcd v=%0d got=%h exp=%h", v, bcd_out(), model_bcd(v)); end
      total++; if (ovf !== (v > 9999)) begin bad++; $display("FAIL rand_ovf v=%0d got=%b exp=%b", v, ovf, v > 9999); end
      total++; if (lat !== LAT || dc !== 1) begin bad++; $display("FAIL rand_timing v=%0d lat=%0d done_cycles=%0d exp=%0d/1", v, lat, dc, LAT); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bin = '0;
    test_reset();
    test_zero();
    test_1234();
    test_limits();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
